// File: rtl/button_gesture_decoder.sv
// Turns a debounced button level into press/release/click/double-click/long-press pulses.
// Define GESTURE_REPEAT_EN to enable auto-repeat pulses while held after a long press.
module button_gesture_decoder #(
  parameter int unsigned LONG_TICKS   = 50_000_000,
  parameter int unsigned DOUBLE_TICKS = 12_000_000,
  parameter int unsigned REPEAT_TICKS = 10_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic debounced_in,
  output logic press_pulse,
  output logic release_pulse,
  output logic short_click,
  output logic double_click,
  output logic long_press,
  output logic repeat_pulse,
  output logic busy
);

  // state    | meaning
  // S_IDLE   | no gesture in progress
  // S_PRESS1 | first press held, timing toward long press
  // S_GAP    | released once, waiting for a second press
  // S_PRESS2 | second press held, double click unless it becomes a long press
  // S_HELD   | long press reported, waiting for release
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_PRESS1 = 3'd1,
    S_GAP    = 3'd2,
    S_PRESS2 = 3'd3,
    S_HELD   = 3'd4
  } state_t;

  localparam int unsigned MAX_LD    = (LONG_TICKS > DOUBLE_TICKS) ? LONG_TICKS : DOUBLE_TICKS;
  localparam int unsigned MAX_TICKS = (MAX_LD > REPEAT_TICKS) ? MAX_LD : REPEAT_TICKS;
  localparam int unsigned CNT_W     = $clog2(MAX_TICKS + 1);

  localparam logic [CNT_W-1:0] CNT_MAX   = '1;
  localparam logic [CNT_W-1:0] LONG_TC   = CNT_W'(LONG_TICKS - 1);
  localparam logic [CNT_W-1:0] DOUBLE_TC = CNT_W'(DOUBLE_TICKS - 1);
`ifdef GESTURE_REPEAT_EN
  localparam logic [CNT_W-1:0] REPEAT_TC = CNT_W'(REPEAT_TICKS - 1);
`endif

  state_t           state;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] count_inc;
  logic             level_q;
  logic             rise;
  logic             fall;

  assign rise = debounced_in & ~level_q;
  assign fall = ~debounced_in & level_q;

  // Terminal compares fire one count early so the pulse lands exactly N cycles after its trigger.
  assign count_inc = (count == CNT_MAX) ? count : count + CNT_W'(1);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= S_IDLE;
      count         <= '0;
      level_q       <= 1'b0;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      short_click   <= 1'b0;
      double_click  <= 1'b0;
      long_press    <= 1'b0;
      repeat_pulse  <= 1'b0;
      busy          <= 1'b0;
    end else begin
      level_q       <= debounced_in;
      press_pulse   <= rise;
      release_pulse <= fall;
      short_click   <= 1'b0;
      double_click  <= 1'b0;
      long_press    <= 1'b0;
      repeat_pulse  <= 1'b0;

      case (state)
        S_IDLE: begin
          count <= '0;
          if (rise) begin
            state <= S_PRESS1;
            busy  <= 1'b1;
          end
        end

        S_PRESS1: begin
          if (count == LONG_TC) begin
            long_press <= 1'b1;
            state      <= S_HELD;
            count      <= '0;
          end else if (fall) begin
            state <= S_GAP;
            count <= '0;
          end else begin
            count <= count_inc;
          end
        end

        // A rise on the expiry cycle still counts as the second press.
        S_GAP: begin
          if (rise) begin
            state <= S_PRESS2;
            count <= '0;
          end else if (count == DOUBLE_TC) begin
            short_click <= 1'b1;
            state       <= S_IDLE;
            busy        <= 1'b0;
            count       <= '0;
          end else begin
            count <= count_inc;
          end
        end

        S_PRESS2: begin
          if (count == LONG_TC) begin
            long_press <= 1'b1;
            state      <= S_HELD;
            count      <= '0;
          end else if (fall) begin
            double_click <= 1'b1;
            state        <= S_IDLE;
            busy         <= 1'b0;
            count        <= '0;
          end else begin
            count <= count_inc;
          end
        end

        // Level check, so a release coinciding with the long-press terminal count exits here.
        S_HELD: begin
          if (!debounced_in) begin
            state <= S_IDLE;
            busy  <= 1'b0;
            count <= '0;
          end else begin
`ifdef GESTURE_REPEAT_EN
            if (count == REPEAT_TC) begin
              repeat_pulse <= 1'b1;
              count        <= '0;
            end else begin
              count <= count_inc;
            end
`else
            count <= '0;
`endif
          end
        end

        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
          count <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_button_gesture_decoder.sv
// Directed bench for button_gesture_decoder: expected pulses are queued per clock edge
// at stimulus time and compared every cycle against the DUT outputs.
module tb_button_gesture_decoder;

  logic clk = 1'b0;
  logic rst;
  logic debounced_in;
  logic press_pulse, release_pulse, short_click, double_click, long_press, repeat_pulse, busy;

  int vectors     = 0;
  int miscompares = 0;
  int cyc         = 0;

  localparam logic [5:0] EV_PRESS  = 6'b100000;
  localparam logic [5:0] EV_REL    = 6'b010000;
  localparam logic [5:0] EV_SHORT  = 6'b001000;
  localparam logic [5:0] EV_DOUBLE = 6'b000100;
  localparam logic [5:0] EV_LONG   = 6'b000010;
  localparam logic [5:0] EV_REP    = 6'b000001;

  typedef struct {
    int         cyc;
    logic [5:0] vec;
  } exp_t;

  exp_t exp_q[$];

  button_gesture_decoder #(
    .LONG_TICKS  (8),
    .DOUBLE_TICKS(5),
    .REPEAT_TICKS(4)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .debounced_in (debounced_in),
    .press_pulse  (press_pulse),
    .release_pulse(release_pulse),
    .short_click  (short_click),
    .double_click (double_click),
    .long_press   (long_press),
    .repeat_pulse (repeat_pulse),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Events caused by posedge number c are visible at the negedge that follows it.
  task automatic expect_ev(input int c, input logic [5:0] v);
    exp_t t;
    if (exp_q.size() > 0 && exp_q[exp_q.size()-1].cyc == c) begin
      t = exp_q[exp_q.size()-1];
      t.vec = t.vec | v;
      exp_q[exp_q.size()-1] = t;
    end else begin
      t.cyc = c;
      t.vec = v;
      exp_q.push_back(t);
    end
  endtask

  task automatic hold(input logic v, input int n);
    debounced_in = v;
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic chk_busy(input logic e, input string tag);
    vectors++;
    assert (busy === e) else begin
      miscompares++;
      $error("FAIL %s: busy observed %b expected %b", tag, busy, e);
    end
  endtask

  task automatic chk_async_reset(input string tag);
    logic [6:0] obs;
    obs = {press_pulse, release_pulse, short_click, double_click, long_press, repeat_pulse, busy};
    vectors++;
    assert (obs === 7'b0) else begin
      miscompares++;
      $error("FAIL %s: outputs observed %b expected %b", tag, obs, 7'b0);
    end
  endtask

  logic [5:0] mon_obs, mon_exp;
  always @(negedge clk) begin
    mon_obs = {press_pulse, release_pulse, short_click, double_click, long_press, repeat_pulse};
    mon_exp = 6'b0;
    if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
      mon_exp = exp_q[0].vec;
      void'(exp_q.pop_front());
    end
    vectors++;
    assert (mon_obs === mon_exp) else begin
      miscompares++;
      $error("FAIL events@%0d: observed %b expected %b (press,rel,short,dbl,long,rep)",
             cyc, mon_obs, mon_exp);
    end
  end

  initial begin
    int p, p2, r;
    rst          = 1'b0;
    debounced_in = 1'b1;

    // Reset held with input high: nothing fires.
    repeat (3) @(posedge clk);
    #2;
    chk_busy(1'b0, "reset_busy");

    // Release with input high: level_q starts at 0 so exactly one press is seen.
    rst = 1'b1;
    p = cyc + 1;
    expect_ev(p, EV_PRESS);
    hold(1'b1, 3);
    chk_busy(1'b1, "post_reset_press_busy");
    rst = 1'b0;
    #1;
    chk_async_reset("reset_abort_press");
    debounced_in = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    rst = 1'b1;
    hold(1'b0, 3);
    chk_busy(1'b0, "after_abort_idle");

    // Single click.
    p = cyc + 1;
    r = p + 3;
    expect_ev(p, EV_PRESS);
    expect_ev(r, EV_REL);
    expect_ev(r + 5, EV_SHORT);
    hold(1'b1, 3);
    hold(1'b0, 4);
    chk_busy(1'b1, "click_gap_busy");
    hold(1'b0, 4);
    chk_busy(1'b0, "click_done_busy");

    // Double click: gap of two cycles.
    p = cyc + 1;
    r = p + 3;
    p2 = r + 2;
    expect_ev(p, EV_PRESS);
    expect_ev(r, EV_REL);
    expect_ev(p2, EV_PRESS);
    expect_ev(p2 + 3, EV_REL | EV_DOUBLE);
    hold(1'b1, 3);
    hold(1'b0, 2);
    hold(1'b1, 3);
    hold(1'b0, 8);
    chk_busy(1'b0, "double_done_busy");

    // Long press held 12 cycles, release gives no click.
    p = cyc + 1;
    expect_ev(p, EV_PRESS);
    expect_ev(p + 8, EV_LONG);
    expect_ev(p + 12, EV_REL);
    hold(1'b1, 12);
    chk_busy(1'b1, "long_held_busy");
    hold(1'b0, 8);
    chk_busy(1'b0, "long_done_busy");

    // Second rise exactly on gap expiry: double click, no short click.
    p = cyc + 1;
    r = p + 3;
    p2 = r + 5;
    expect_ev(p, EV_PRESS);
    expect_ev(r, EV_REL);
    expect_ev(p2, EV_PRESS);
    expect_ev(p2 + 2, EV_REL | EV_DOUBLE);
    hold(1'b1, 3);
    hold(1'b0, 5);
    hold(1'b1, 2);
    hold(1'b0, 8);

    // Release on the long-press terminal cycle: long press only.
    p = cyc + 1;
    expect_ev(p, EV_PRESS);
    expect_ev(p + 8, EV_REL | EV_LONG);
    hold(1'b1, 8);
    hold(1'b0, 1);
    chk_busy(1'b1, "long_tc_fall_busy");
    hold(1'b0, 1);
    chk_busy(1'b0, "long_tc_fall_idle");
    hold(1'b0, 8);

    // Second press held long: long press replaces the double click.
    p = cyc + 1;
    r = p + 2;
    p2 = r + 2;
    expect_ev(p, EV_PRESS);
    expect_ev(r, EV_REL);
    expect_ev(p2, EV_PRESS);
    expect_ev(p2 + 8, EV_LONG);
    expect_ev(p2 + 10, EV_REL);
    hold(1'b1, 2);
    hold(1'b0, 2);
    hold(1'b1, 10);
    hold(1'b0, 8);
    chk_busy(1'b0, "press2_long_idle");

    // Hold 21 edges: repeats at +12, +16, +20 only when the feature is built in.
    p = cyc + 1;
    expect_ev(p, EV_PRESS);
    expect_ev(p + 8, EV_LONG);
`ifdef GESTURE_REPEAT_EN
    expect_ev(p + 12, EV_REP);
    expect_ev(p + 16, EV_REP);
    expect_ev(p + 20, EV_REP);
`endif
    expect_ev(p + 21, EV_REL);
    hold(1'b1, 21);
    hold(1'b0, 8);
    chk_busy(1'b0, "repeat_done_idle");

    // Reset in the middle of a held long press.
    p = cyc + 1;
    expect_ev(p, EV_PRESS);
    expect_ev(p + 8, EV_LONG);
    hold(1'b1, 10);
    chk_busy(1'b1, "midhold_busy");
    rst = 1'b0;
    #1;
    chk_async_reset("midhold_reset");
    debounced_in = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    rst = 1'b1;
    hold(1'b0, 6);
    chk_busy(1'b0, "final_idle");

    vectors++;
    assert (exp_q.size() == 0) else begin
      miscompares++;
      $error("FAIL pending_events: observed %0d left expected 0", exp_q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
